// File: rtl/sram_bist_pkg.sv
// Shared definitions for the March C- SRAM BIST: FSM state encodings, element
// indices and the per-element operation table.
package sram_bist_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WRITE    = 3'd1;
  localparam logic [2:0] ST_RD_ISSUE = 3'd2;
  localparam logic [2:0] ST_RD_WAIT  = 3'd3;
  localparam logic [2:0] ST_NEXT     = 3'd4;
  localparam logic [2:0] ST_FINISH   = 3'd5;

  localparam logic [2:0] ELEM_M0 = 3'd0;
  localparam logic [2:0] ELEM_M1 = 3'd1;
  localparam logic [2:0] ELEM_M2 = 3'd2;
  localparam logic [2:0] ELEM_M3 = 3'd3;
  localparam logic [2:0] ELEM_M4 = 3'd4;
  localparam logic [2:0] ELEM_M5 = 3'd5;

  typedef struct packed {
    logic down;
    logic has_read;
    logic read_inv;
    logic has_write;
    logic write_inv;
  } elem_cfg_t;

  // Fields: down, has_read, read_inv, has_write, write_inv. Rows 6-7 pad the 3-bit index.
  localparam elem_cfg_t ELEM_TABLE [8] = '{
    ELEM_M0: '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
    ELEM_M1: '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
    ELEM_M2: '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
    ELEM_M3: '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
    ELEM_M4: '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
    ELEM_M5: '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    default: '0
  };

endpackage

// File: rtl/march_addr_gen.sv
// Up/down address counter for one March element: loads 0 or N-1, steps in the
// loaded direction and flags the element's final address.
module march_addr_gen #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  logic down;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr <= '0;
      down <= 1'b0;
    end else if (load) begin
      down <= load_down;
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
    end
  end

  assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer driving port 0 of a single-port OpenRAM macro and
// recording the first read mismatch.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int WMASK_WIDTH  = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                   wb_clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  pattern,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [2:0]             fail_element,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0]  fail_expected,
  output logic [DATA_WIDTH-1:0]  fail_data,
  output logic                   csb0,
  output logic                   web0,
  output logic [WMASK_WIDTH-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0]  addr0,
  output logic [DATA_WIDTH-1:0]  din0,
  input  logic [DATA_WIDTH-1:0]  dout0
);
  logic [2:0]            state, element, elem_next, after_op;
  logic [1:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] bg, wr_value, rd_expected;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last, wait_done, mismatch, op_end, run_end;
  logic                  load, load_down, step;

  assign elem_next   = element + 3'd1;
  assign wr_value    = ELEM_TABLE[element].write_inv ? ~bg : bg;
  assign rd_expected = ELEM_TABLE[element].read_inv ? ~bg : bg;
  assign wait_done   = (wait_cnt == 2'(READ_LATENCY - 1));
  // Case inequality so an X on the read bus is reported rather than ignored.
  assign mismatch    = (dout0 !== rd_expected);
  assign op_end      = (state == ST_WRITE) ||
                       (state == ST_RD_WAIT && wait_done && !mismatch && !ELEM_TABLE[element].has_write);
  assign run_end     = op_end && last && (element == ELEM_M5);
  assign load        = (state == ST_IDLE && start) || (op_end && last);
  assign load_down   = (state == ST_IDLE) ? ELEM_TABLE[ELEM_M0].down : ELEM_TABLE[elem_next].down;
  assign step        = op_end && !last;

  march_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clock     (wb_clock),
    .reset     (reset),
    .load      (load),
    .load_down (load_down),
    .step      (step),
    .addr      (addr),
    .last      (last)
  );

  // Address stepping is folded into the last op of each address, so NEXT is never visited.
  always_comb begin
    after_op = ELEM_TABLE[element].has_read ? ST_RD_ISSUE : ST_WRITE;
    if (run_end)
      after_op = ST_FINISH;
    else if (last)
      after_op = ELEM_TABLE[elem_next].has_read ? ST_RD_ISSUE : ST_WRITE;
  end

  always_ff @(posedge wb_clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      element       <= ELEM_M0;
      wait_cnt      <= '0;
      bg            <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_element  <= '0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_data     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bg            <= pattern;
            element       <= ELEM_M0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_element  <= '0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_data     <= '0;
            state         <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          state <= after_op;
          if (last) element <= elem_next;
        end
        ST_RD_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (!wait_done) begin
            wait_cnt <= wait_cnt + 2'd1;
          end else if (mismatch) begin
            fail_element  <= element;
            fail_addr     <= addr;
            fail_expected <= rd_expected;
            fail_data     <= dout0;
            busy          <= 1'b0;
            done          <= 1'b1;
            pass          <= 1'b0;
            state         <= ST_FINISH;
          end else if (ELEM_TABLE[element].has_write) begin
            state <= ST_WRITE;
          end else begin
            state <= after_op;
            if (run_end) begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= 1'b1;
            end else if (last) begin
              element <= elem_next;
            end
          end
        end
        ST_NEXT, ST_FINISH: state <= ST_IDLE;
        default:            state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    if (state == ST_WRITE) begin
      csb0   = 1'b0;
      web0   = 1'b0;
      wmask0 = '1;
      addr0  = addr;
      din0   = wr_value;
    end else if (state == ST_RD_ISSUE) begin
      csb0  = 1'b0;
      addr0 = addr;
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist: two instances (read latency 1 and 2)
// against behavioural macro models and a March C- reference model.
module tb_sram_march_bist;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 16;

  typedef struct {
    bit          ok;
    logic [2:0]  elem;
    logic [3:0]  addr;
    logic [31:0] expd;
    logic [31:0] data;
    int          cycles;
    logic [31:0] pat;
  } exp_t;

  logic wb_clock = 1'b0;
  logic reset;
  logic start, start_2;
  logic [DW-1:0] pattern, pattern_2;
  logic busy, done, pass, busy_2, done_2, pass_2;
  logic [2:0] fail_element, fail_element_2;
  logic [AW-1:0] fail_addr, fail_addr_2, addr0, addr0_2;
  logic [DW-1:0] fail_expected, fail_data, fail_expected_2, fail_data_2;
  logic csb0, web0, csb0_2, web0_2;
  logic [3:0] wmask0, wmask0_2;
  logic [DW-1:0] din0, dout0, din0_2, dout0_2;

  int tests_run = 0;
  int fail_count = 0;

  exp_t sb1[$];
  exp_t sb2[$];

  bit f_en;
  int f_addr, f_bit;
  bit f_val;

  bit desc_dir [6] = '{0, 0, 0, 1, 1, 0};
  bit rd_op    [6] = '{0, 1, 1, 1, 1, 1};
  bit rd_inv   [6] = '{0, 0, 1, 0, 1, 0};
  bit wr_op    [6] = '{1, 1, 1, 1, 1, 0};
  bit wr_inv   [6] = '{0, 1, 0, 1, 0, 0};

  always #5 wb_clock = ~wb_clock;

  sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(4), .READ_LATENCY(1)) dut (
    .wb_clock(wb_clock), .reset(reset), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .pass(pass), .fail_element(fail_element),
    .fail_addr(fail_addr), .fail_expected(fail_expected), .fail_data(fail_data),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(4), .READ_LATENCY(2)) dut_2 (
    .wb_clock(wb_clock), .reset(reset), .start(start_2), .pattern(pattern_2),
    .busy(busy_2), .done(done_2), .pass(pass_2), .fail_element(fail_element_2),
    .fail_addr(fail_addr_2), .fail_expected(fail_expected_2), .fail_data(fail_data_2),
    .csb0(csb0_2), .web0(web0_2), .wmask0(wmask0_2), .addr0(addr0_2), .din0(din0_2), .dout0(dout0_2)
  );

  // Macro models: byte-masked writes, optional stuck-at bit on reads of one cell.
  logic [31:0] mem1 [N];
  logic [31:0] mem2 [N];
  logic [31:0] rd1, rd2a, rd2b;

  function automatic logic [31:0] faulty(logic [31:0] v, int a);
    if (f_en && a == f_addr) v[f_bit] = f_val;
    return v;
  endfunction

  always @(posedge wb_clock) begin
    if (!csb0 && !web0)
      for (int b = 0; b < 4; b++)
        if (wmask0[b]) mem1[addr0][8*b +: 8] <= din0[8*b +: 8];
    if (!csb0 && web0) rd1 <= faulty(mem1[addr0], int'(addr0));
  end
  assign dout0 = rd1;

  always @(posedge wb_clock) begin
    if (!csb0_2 && !web0_2)
      for (int b = 0; b < 4; b++)
        if (wmask0_2[b]) mem2[addr0_2][8*b +: 8] <= din0_2[8*b +: 8];
    if (!csb0_2 && web0_2) rd2a <= mem2[addr0_2];
    rd2b <= rd2a;
  end
  assign dout0_2 = rd2b;

  // Walks the March C- elements over an array; busy time is 1 per write, 1+lat per read.
  function automatic exp_t ref_model(logic [31:0] b, int lat, bit fe, int fa, int fb, bit fv);
    logic [31:0] m [N];
    logic [31:0] v, want;
    int a;
    exp_t e;
    e = '{ok: 1'b1, elem: '0, addr: '0, expd: '0, data: '0, cycles: 0, pat: b};
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int el = 0; el < 6; el++) begin
      for (int k = 0; k < N; k++) begin
        a = desc_dir[el] ? N - 1 - k : k;
        if (rd_op[el]) begin
          e.cycles += 1 + lat;
          v = m[a];
          if (fe && a == fa) v[fb] = fv;
          want = rd_inv[el] ? ~b : b;
          if (v != want) begin
            e.ok = 1'b0; e.elem = 3'(el); e.addr = 4'(a); e.expd = want; e.data = v;
            return e;
          end
        end
        if (wr_op[el]) begin
          e.cycles += 1;
          m[a] = wr_inv[el] ? ~b : b;
        end
      end
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      fail_count++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_result(string tag, exp_t e, logic p, logic [2:0] fe, logic [3:0] fa,
                              logic [31:0] fx, logic [31:0] fd, int cyc, int bad_words);
    check({tag, "_pass"}, 32'(p), 32'(e.ok));
    check({tag, "_busy_cycles"}, cyc, e.cycles);
    check({tag, "_fail_element"}, 32'(fe), 32'(e.elem));
    check({tag, "_fail_addr"}, 32'(fa), 32'(e.addr));
    check({tag, "_fail_expected"}, fx, e.expd);
    check({tag, "_fail_data"}, fd, e.data);
    if (e.ok) check({tag, "_final_mem_bad_words"}, bad_words, 0);
  endtask

  // Monitors: count busy cycles, pop the expected result when done rises.
  int cnt1, cnt2, bad;
  logic done_q1, done_q2;
  exp_t e1, e2;

  always @(negedge wb_clock) begin
    if (!reset) begin
      cnt1 = 0; done_q1 = 1'b0;
    end else begin
      if (busy) cnt1++;
      if (done && !done_q1) begin
        if (sb1.size() == 0) begin
          tests_run++; fail_count++;
          $display("[TB] FAIL unexpected_done: actual done=1 required no result pending");
        end else begin
          e1 = sb1.pop_front();
          bad = 0;
          for (int i = 0; i < N; i++) if (mem1[i] !== e1.pat) bad++;
          check_result("lat1", e1, pass, fail_element, fail_addr, fail_expected, fail_data, cnt1, bad);
        end
        cnt1 = 0;
      end
      done_q1 = done;
    end
  end

  always @(negedge wb_clock) begin
    if (!reset) begin
      cnt2 = 0; done_q2 = 1'b0;
    end else begin
      if (busy_2) cnt2++;
      if (done_2 && !done_q2) begin
        if (sb2.size() == 0) begin
          tests_run++; fail_count++;
          $display("[TB] FAIL unexpected_done_2: actual done=1 required no result pending");
        end else begin
          e2 = sb2.pop_front();
          bad = 0;
          for (int i = 0; i < N; i++) if (mem2[i] !== e2.pat) bad++;
          check_result("lat2", e2, pass_2, fail_element_2, fail_addr_2, fail_expected_2, fail_data_2, cnt2, bad);
        end
        cnt2 = 0;
      end
      done_q2 = done_2;
    end
  end

  task automatic launch(logic [31:0] pat, bit fe, int fa, int fb, bit fv);
    f_en = fe; f_addr = fa; f_bit = fb; f_val = fv;
    sb1.push_back(ref_model(pat, 1, fe, fa, fb, fv));
    @(posedge wb_clock); #1;
    pattern = pat; start = 1'b1;
    @(posedge wb_clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int k = 0;
    while (!done && k < 2000) begin
      @(negedge wb_clock);
      k++;
    end
    if (!done) begin
      tests_run++; fail_count++;
      $display("[TB] FAIL %s_timeout: actual done=0 required done=1 within 2000 cycles", name);
      sb1.delete();
    end
  endtask

  initial begin
    int lows;
    logic [31:0] pat;
    reset = 1'b0; start = 1'b0; start_2 = 1'b0; pattern = '0; pattern_2 = '0;
    f_en = 1'b0; f_addr = 0; f_bit = 0; f_val = 1'b0;
    #3;
    check("rst_csb0", 32'(csb0), 1);
    check("rst_web0", 32'(web0), 1);
    check("rst_wmask0", 32'(wmask0), 0);
    check("rst_addr0", 32'(addr0), 0);
    check("rst_din0", din0, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail_fields", {29'(fail_element), 3'b0} | 32'(fail_addr) | fail_expected | fail_data, 0);
    repeat (2) @(negedge wb_clock);
    reset = 1'b1;

    launch(32'hA5A5_5A5A, 0, 0, 0, 0);
    wait_done("pass_run");
    repeat (3) @(negedge wb_clock);

    launch(32'h0, 1, 5, 3, 0);
    wait_done("sa0");
    check("sa0_elem", 32'(fail_element), 2);
    check("sa0_addr", 32'(fail_addr), 5);
    check("sa0_expected", fail_expected, 32'hFFFF_FFFF);
    check("sa0_data", fail_data, 32'hFFFF_FFF7);
    repeat (3) @(negedge wb_clock);

    launch(32'h0, 1, 15, 0, 1);
    wait_done("sa1");
    check("sa1_elem", 32'(fail_element), 1);
    check("sa1_data", fail_data, 1);
    lows = 0;
    repeat (10) begin
      @(negedge wb_clock);
      if (!csb0) lows++;
    end
    check("sa1_no_access_after_finish", lows, 0);

    launch(32'hA5A5_5A5A, 0, 0, 0, 0);
    repeat (49) @(posedge wb_clock);
    #1 start = 1'b1;
    @(posedge wb_clock); #1 start = 1'b0;
    wait_done("restart_ignored");
    repeat (3) @(negedge wb_clock);

    launch(32'h1234_5678, 0, 0, 0, 0);
    repeat (99) @(posedge wb_clock);
    #2 reset = 1'b0;
    #1;
    check("abort_csb0", 32'(csb0), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    sb1.delete();
    repeat (2) @(negedge wb_clock);
    reset = 1'b1;
    launch(32'hA5A5_5A5A, 0, 0, 0, 0);
    wait_done("after_abort");
    repeat (3) @(negedge wb_clock);

    for (int r = 0; r < 6; r++) begin
      launch($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      wait_done("random");
      repeat (3) @(negedge wb_clock);
    end

    for (int r = 0; r < 2; r++) begin
      pat = (r == 0) ? 32'hA5A5_5A5A : $urandom;
      sb2.push_back(ref_model(pat, 2, 0, 0, 0, 0));
      @(posedge wb_clock); #1;
      pattern_2 = pat; start_2 = 1'b1;
      @(posedge wb_clock); #1;
      start_2 = 1'b0;
      lows = 0;
      while (!done_2 && lows < 2000) begin
        @(negedge wb_clock);
        lows++;
      end
      if (!done_2) begin
        tests_run++; fail_count++;
        $display("[TB] FAIL lat2_timeout: actual done=0 required done=1 within 2000 cycles");
        sb2.delete();
      end
      repeat (3) @(negedge wb_clock);
    end

    check("leftover_expected", sb1.size() + sb2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual simulation still running required finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
